// File: rtl/tl45_pkg.sv
// Shared opcodes, execute-stage state encoding and the memory-stage buffer payload.
package tl45_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
    localparam logic [OPC_W-1:0] OP_ADD = 5'h01;
    localparam logic [OPC_W-1:0] OP_SUB = 5'h02;
    localparam logic [OPC_W-1:0] OP_MUL = 5'h03;
    localparam logic [OPC_W-1:0] OP_OR  = 5'h06;
    localparam logic [OPC_W-1:0] OP_XOR = 5'h07;
    localparam logic [OPC_W-1:0] OP_AND = 5'h08;
    localparam logic [OPC_W-1:0] OP_SHL = 5'h0A;
    localparam logic [OPC_W-1:0] OP_SHR = 5'h0B;
    localparam logic [OPC_W-1:0] OP_IN  = 5'h10;
    localparam logic [OPC_W-1:0] OP_OUT = 5'h11;
    localparam logic [OPC_W-1:0] OP_LW  = 5'h14;
    localparam logic [OPC_W-1:0] OP_SW  = 5'h15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_MUL_DONE = 2'd2
    } exec_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  dr;
        logic [DATA_W-1:0] sr1_val;
        logic [DATA_W-1:0] sr2_val;
        logic [DATA_W-1:0] imm;
    } exe_buf_t;

    // Single-cycle ALU ops (MUL is handled by the iterative unit).
    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR)  || (op == OP_XOR) ||
               (op == OP_AND) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_IN) || (op == OP_OUT) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/tl45_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// result is the low DATA_W bits of a*b.
module tl45_mul_iter
    import tl45_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned STEPS    = DATA_W / MUL_STEP;
    localparam int unsigned CNT_W    = $clog2(STEPS);
    localparam int unsigned CNT_LAST = STEPS - 1;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] partial_c;

    // Sum of b shifted by each set bit among the MUL_STEP low bits of a.
    always_comb begin
        partial_c = '0;
        for (int k = 0; k < int'(MUL_STEP); k++) begin
            if (a_q[k]) begin
                partial_c = partial_c + (b_q << k);
            end
        end
    end

    // done_q marks the cycle performing the final step; the result is complete after it.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (flush_i) begin
            busy_d = 1'b0;
            done_d = 1'b0;
            cnt_d  = '0;
            a_d    = '0;
            b_d    = '0;
            acc_d  = '0;
        end else if (!stall_i) begin
            if (start_i) begin
                busy_d = 1'b1;
                done_d = 1'b0;
                cnt_d  = '0;
                a_d    = a_i;
                b_d    = b_i;
                acc_d  = '0;
            end else if (busy_q) begin
                acc_d  = acc_q + partial_c;
                a_d    = a_q >> MUL_STEP;
                b_d    = b_q << MUL_STEP;
                cnt_d  = cnt_q + CNT_W'(1);
                done_d = (cnt_d == CNT_W'(CNT_LAST));
                if (done_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = acc_q;

endmodule

// File: rtl/tl45_execute.sv
// tl45 execute stage: ALU, iterative MUL, memory-op pass-through, forwarding and
// stall/flush propagation into the memory-stage input buffer.
module tl45_execute
    import tl45_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_stall,
    output logic              o_pipe_stall,
    input  logic              i_pipe_flush,
    output logic              o_pipe_flush,
    input  logic [OPC_W-1:0]  i_buf_opcode,
    input  logic [REG_W-1:0]  i_buf_dr,
    input  logic [DATA_W-1:0] i_buf_sr1_val,
    input  logic [DATA_W-1:0] i_buf_sr2_val,
    input  logic [DATA_W-1:0] i_buf_imm,
    output logic [OPC_W-1:0]  o_buf_opcode,
    output logic [REG_W-1:0]  o_buf_dr,
    output logic [DATA_W-1:0] o_buf_sr1_val,
    output logic [DATA_W-1:0] o_buf_sr2_val,
    output logic [DATA_W-1:0] o_buf_imm,
    output logic [REG_W-1:0]  o_fwd_dr,
    output logic [DATA_W-1:0] o_fwd_val
);

    exec_state_e       state_q, state_d;
    exe_buf_t          buf_q, buf_d;
    logic [REG_W-1:0]  mul_dr_q, mul_dr_d;
    logic [DATA_W-1:0] op_b_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              mul_start_c;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;

    assign op_b_c = i_buf_sr2_val + i_buf_imm;

    always_comb begin
        alu_res_c = '0;
        case (i_buf_opcode)
            OP_ADD:  alu_res_c = i_buf_sr1_val + op_b_c;
            OP_SUB:  alu_res_c = i_buf_sr1_val - op_b_c;
            OP_OR:   alu_res_c = i_buf_sr1_val | op_b_c;
            OP_XOR:  alu_res_c = i_buf_sr1_val ^ op_b_c;
            OP_AND:  alu_res_c = i_buf_sr1_val & op_b_c;
            OP_SHL:  alu_res_c = i_buf_sr1_val << op_b_c[4:0];
            OP_SHR:  alu_res_c = i_buf_sr1_val >> op_b_c[4:0];
            default: alu_res_c = '0;
        endcase
    end

    // The multiplier applies the same flush > stall > start priority as this stage.
    assign mul_start_c = (state_q == ST_IDLE) && (i_buf_opcode == OP_MUL);

    tl45_mul_iter #(
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .stall_i  (i_pipe_stall),
        .flush_i  (i_pipe_flush),
        .start_i  (mul_start_c),
        .a_i      (i_buf_sr1_val),
        .b_i      (op_b_c),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_result)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        mul_dr_d = mul_dr_q;
        if (i_pipe_flush) begin
            buf_d   = '0;
            state_d = ST_IDLE;
        end else if (!i_pipe_stall) begin
            case (state_q)
                ST_IDLE: begin
                    buf_d = '0;
                    if (is_alu_op(i_buf_opcode)) begin
                        buf_d.dr      = i_buf_dr;
                        buf_d.sr1_val = alu_res_c;
                    end else if (is_mem_op(i_buf_opcode)) begin
                        buf_d.opcode  = i_buf_opcode;
                        buf_d.dr      = i_buf_dr;
                        buf_d.sr1_val = i_buf_sr1_val;
                        buf_d.sr2_val = i_buf_sr2_val;
                        buf_d.imm     = i_buf_imm;
                    end else if (i_buf_opcode == OP_MUL) begin
                        mul_dr_d = i_buf_dr;
                        state_d  = ST_MUL_BUSY;
                    end
                end
                ST_MUL_BUSY: begin
                    buf_d = '0;
                    if (mul_busy && mul_done) begin
                        state_d = ST_MUL_DONE;
                    end
                end
                ST_MUL_DONE: begin
                    buf_d         = '0;
                    buf_d.dr      = mul_dr_q;
                    buf_d.sr1_val = mul_result;
                    state_d       = ST_IDLE;
                end
                default: begin
                    buf_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            mul_dr_q <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            mul_dr_q <= mul_dr_d;
        end
    end

    assign o_pipe_stall  = i_pipe_stall | (state_q != ST_IDLE);
    assign o_pipe_flush  = i_pipe_flush;
    assign o_buf_opcode  = buf_q.opcode;
    assign o_buf_dr      = buf_q.dr;
    assign o_buf_sr1_val = buf_q.sr1_val;
    assign o_buf_sr2_val = buf_q.sr2_val;
    assign o_buf_imm     = buf_q.imm;

    // Only ALU/MUL results (opcode NOP in the buffer) with a real destination forward.
    assign o_fwd_dr  = (buf_q.opcode == OP_NOP && buf_q.dr != '0) ? buf_q.dr : '0;
    assign o_fwd_val = (buf_q.opcode == OP_NOP && buf_q.dr != '0) ? buf_q.sr1_val : '0;

endmodule

// File: tb/tb_tl45_execute.sv
// Scoreboard bench for tl45_execute: directed cases plus randomized ops with random stalls.
module tb_tl45_execute;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_stall = 1'b0;
    logic        o_pipe_stall;
    logic        i_pipe_flush = 1'b0;
    logic        o_pipe_flush;
    logic [4:0]  i_buf_opcode = '0;
    logic [3:0]  i_buf_dr = '0;
    logic [31:0] i_buf_sr1_val = '0;
    logic [31:0] i_buf_sr2_val = '0;
    logic [31:0] i_buf_imm = '0;
    logic [4:0]  o_buf_opcode;
    logic [3:0]  o_buf_dr;
    logic [31:0] o_buf_sr1_val;
    logic [31:0] o_buf_sr2_val;
    logic [31:0] o_buf_imm;
    logic [3:0]  o_fwd_dr;
    logic [31:0] o_fwd_val;

    always #5 i_clk = ~i_clk;

    tl45_execute #(.MUL_STEP(1)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_pipe_stall  (i_pipe_stall),
        .o_pipe_stall  (o_pipe_stall),
        .i_pipe_flush  (i_pipe_flush),
        .o_pipe_flush  (o_pipe_flush),
        .i_buf_opcode  (i_buf_opcode),
        .i_buf_dr      (i_buf_dr),
        .i_buf_sr1_val (i_buf_sr1_val),
        .i_buf_sr2_val (i_buf_sr2_val),
        .i_buf_imm     (i_buf_imm),
        .o_buf_opcode  (o_buf_opcode),
        .o_buf_dr      (o_buf_dr),
        .o_buf_sr1_val (o_buf_sr1_val),
        .o_buf_sr2_val (o_buf_sr2_val),
        .o_buf_imm     (o_buf_imm),
        .o_fwd_dr      (o_fwd_dr),
        .o_fwd_val     (o_fwd_val)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  dr;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] im;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    bit   rand_stall_en = 1'b0;

    // What the memory stage should receive for one accepted instruction.
    function automatic exp_t ref_model(input logic [4:0] op, input logic [3:0] dr,
                                       input logic [31:0] s1, input logic [31:0] s2,
                                       input logic [31:0] im);
        logic [31:0] a, b, r;
        exp_t e;
        a = s1;
        b = s2 + im;
        e = '0;
        r = '0;
        case (op)
            5'h01: r = a + b;
            5'h02: r = a - b;
            5'h03: r = a * b;
            5'h06: r = a | b;
            5'h07: r = a ^ b;
            5'h08: r = a & b;
            5'h0A: r = a << b[4:0];
            5'h0B: r = a >> b[4:0];
            default: r = '0;
        endcase
        case (op)
            5'h01, 5'h02, 5'h03, 5'h06, 5'h07, 5'h08, 5'h0A, 5'h0B: begin
                e.dr = dr;
                e.v1 = r;
            end
            5'h10, 5'h11, 5'h14, 5'h15: e = '{op, dr, s1, s2, im};
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every buffer update that produces a non-zero payload consumes one expectation.
    always @(posedge i_clk) begin : monitor
        bit          upd;
        exp_t        act;
        exp_t        e;
        logic [3:0]  efd;
        logic [31:0] efv;
        upd = mon_en && !i_reset && !i_pipe_stall && !i_pipe_flush;
        #1;
        act = '{o_buf_opcode, o_buf_dr, o_buf_sr1_val, o_buf_sr2_val, o_buf_imm};
        if (upd && act != '0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected nothing", act);
            end else begin
                e = sb_q.pop_front();
                efd = (e.op == 5'h00 && e.dr != 4'h0) ? e.dr : 4'h0;
                efv = (e.op == 5'h00 && e.dr != 4'h0) ? e.v1 : 32'h0;
                if (act !== e || o_fwd_dr !== efd || o_fwd_val !== efv) begin
                    errors++;
                    $display("FAIL buffer_output: got %h fwd %h/%h expected %h fwd %h/%h",
                             act, o_fwd_dr, o_fwd_val, e, efd, efv);
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (rand_stall_en) i_pipe_stall = ($urandom_range(3) == 0);
    end

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] im);
        bit   acc;
        int   guard;
        exp_t e;
        i_buf_opcode  = op;
        i_buf_dr      = dr;
        i_buf_sr1_val = s1;
        i_buf_sr2_val = s2;
        i_buf_imm     = im;
        acc   = 1'b0;
        guard = 0;
        while (!acc) begin
            #1;
            acc = !o_pipe_stall && !i_pipe_flush && !i_reset;
            @(posedge i_clk);
            if (!acc) begin
                guard++;
                if (guard > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: op %h not accepted within 500 cycles", op);
                    break;
                end
                @(negedge i_clk);
            end
        end
        if (acc) begin
            e = ref_model(op, dr, s1, s2, im);
            if (e != '0) sb_q.push_back(e);
        end
        @(negedge i_clk);
        i_buf_opcode  = '0;
        i_buf_dr      = '0;
        i_buf_sr1_val = '0;
        i_buf_sr2_val = '0;
        i_buf_imm     = '0;
    endtask

    // Counts negedges with o_pipe_stall high; optional i_pipe_stall burst after stall_at samples.
    task automatic count_stall(input int stall_at, input int stall_len, output int n);
        n = 0;
        for (int g = 0; g < 300; g++) begin
            #1;
            if (!o_pipe_stall) break;
            n++;
            if (stall_at > 0 && n == stall_at) i_pipe_stall = 1'b1;
            if (stall_at > 0 && n == stall_at + stall_len) i_pipe_stall = 1'b0;
            @(negedge i_clk);
        end
    endtask

    initial begin
        int          n;
        logic [4:0]  ops [15];
        logic [4:0]  op;
        logic [31:0] s1, s2, im;
        ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h06, 5'h07, 5'h08, 5'h0A, 5'h0B,
                5'h10, 5'h11, 5'h14, 5'h15, 5'h04, 5'h1F};

        repeat (3) @(negedge i_clk);
        i_pipe_stall = 1'b1;
        #1 check("reset_stall_follows_in_hi", 32'(o_pipe_stall), 32'h1);
        i_pipe_stall = 1'b0;
        #1 check("reset_stall_follows_in_lo", 32'(o_pipe_stall), 32'h0);
        check("reset_buf_opcode", 32'(o_buf_opcode), 32'h0);
        check("reset_buf_sr1", o_buf_sr1_val, 32'h0);
        check("reset_fwd_dr", 32'(o_fwd_dr), 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        mon_en  = 1'b1;

        issue(5'h01, 4'd3, 32'd5, 32'd0, 32'd7);
        check("add_fwd_dr", 32'(o_fwd_dr), 32'd3);
        check("add_fwd_val", o_fwd_val, 32'd12);
        issue(5'h02, 4'd4, 32'd0, 32'd1, 32'd0);
        check("sub_wrap", o_buf_sr1_val, 32'hFFFF_FFFF);
        issue(5'h0A, 4'd5, 32'd1, 32'd0, 32'd31);
        check("shl_31", o_buf_sr1_val, 32'h8000_0000);
        issue(5'h15, 4'd0, 32'h100, 32'hAB, 32'd4);
        check("sw_imm_passed", o_buf_imm, 32'd4);
        check("sw_no_fwd", 32'(o_fwd_dr), 32'h0);
        issue(5'h01, 4'd0, 32'd10, 32'd20, 32'd0);
        check("dr0_no_fwd", 32'(o_fwd_dr), 32'h0);

        issue(5'h03, 4'd7, 32'h0001_0001, 32'd3, 32'd0);
        count_stall(0, 0, n);
        check("mul_stall_cycles", 32'(n), 32'd33);
        check("mul_result_0x30003", o_buf_sr1_val, 32'h0003_0003);

        issue(5'h03, 4'd9, 32'hFFFF_FFFF, 32'd2, 32'd0);
        count_stall(10, 5, n);
        check("mul_stall_cycles_with_stall", 32'(n), 32'd38);
        check("mul_result_fffffffe", o_buf_sr1_val, 32'hFFFF_FFFE);

        // Flush in the same cycle as a MUL start: no MUL may begin.
        i_buf_opcode  = 5'h03;
        i_buf_dr      = 4'd2;
        i_buf_sr1_val = 32'd6;
        i_buf_sr2_val = 32'd7;
        i_pipe_flush  = 1'b1;
        #1 check("flush_passthrough", 32'(o_pipe_flush), 32'h1);
        @(negedge i_clk);
        i_pipe_flush  = 1'b0;
        i_buf_opcode  = '0;
        i_buf_dr      = '0;
        i_buf_sr1_val = '0;
        i_buf_sr2_val = '0;
        #1 check("flush_at_start_no_busy", 32'(o_pipe_stall), 32'h0);
        check("flush_at_start_buf", 32'(o_buf_dr), 32'h0);
        @(negedge i_clk);

        // Flush around MUL cycle 10 abandons the multiply.
        issue(5'h03, 4'd6, 32'd7, 32'd5, 32'd0);
        repeat (9) @(negedge i_clk);
        i_pipe_flush = 1'b1;
        #1 check("flush_mid_busy", 32'(o_pipe_stall), 32'h1);
        @(negedge i_clk);
        i_pipe_flush = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        #1 check("flush_mid_stall_low", 32'(o_pipe_stall), 32'h0);
        check("flush_mid_buf_dr", 32'(o_buf_dr), 32'h0);
        check("flush_mid_buf_sr1", o_buf_sr1_val, 32'h0);
        check("flush_mid_fwd", 32'(o_fwd_dr), 32'h0);
        @(negedge i_clk);

        rand_stall_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(14)];
            s1 = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            s2 = ($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom;
            im = ($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom;
            issue(op, 4'($urandom_range(15)), s1, s2, im);
        end
        rand_stall_en = 1'b0;
        @(negedge i_clk);
        i_pipe_stall = 1'b0;
        repeat (60) @(negedge i_clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
